// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle control FSM for the RISC core.
// Drives the PC counter, instruction register, RAM and register-file
// datapath through fetch, decode and execute. Moore machine: all outputs
// are decoded from the current state, the wait counter and the latched
// opcode/op fields.
//
// Optional feature: define SEQ_STEP_EN for single-step mode. Each finished
// instruction then parks in STEP_WAIT until a `step` pulse.
//
// Parameters:
//   MEM_WAIT   extra RAM wait cycles per memory state (0..7)
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   opcode[2:0], op[1:0]       IR[15:13], IR[12:11]
//   step                       single-step advance (SEQ_STEP_EN only)
//   pc_reset, loadpc, msel     PC counter / RAM address control
//   mwrite, loadir             RAM write enable, IR load
//   loada/loadb/loadc/loads    datapath register loads
//   asel, bsel, nsel, vsel     datapath selects
//   write                      register-file write enable
//   instr_done, halted         status
module fetch_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       step,
    output logic       pc_reset,
    output logic       loadpc,
    output logic       msel,
    output logic       mwrite,
    output logic       loadir,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [2:0] MW = 3'(MEM_WAIT);

    typedef enum logic [4:0] {
        S_RST,
        S_FETCH,
        S_LOADIR,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_SHIFT,
        S_EXEC,
        S_WR_C,
        S_ADDR,
        S_MEM_RD,
        S_WR_MEM,
        S_GET_B_RD,
        S_MEM_WR,
`ifdef SEQ_STEP_EN
        S_STEP_WAIT,
`endif
        S_HALT
    } state_t;

    // Where an instruction goes after its instr_done cycle.
`ifdef SEQ_STEP_EN
    localparam state_t AFTER_DONE = S_STEP_WAIT;
`else
    localparam state_t AFTER_DONE = S_FETCH;
    logic unused_step;
    assign unused_step = step;
`endif

    state_t     state, state_nx;
    logic [2:0] wcnt;
    logic [2:0] opc_q;
    logic [1:0] op_q;
    logic       mem_last;

    // Last cycle of a memory state once MEM_WAIT extra cycles have elapsed.
    assign mem_last = (wcnt == MW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            wcnt  <= '0;
            opc_q <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            // Counter restarts on every state entry; in long-lived states
            // (HALT, STEP_WAIT) it simply wraps and is ignored.
            wcnt  <= (state_nx != state) ? 3'd0 : wcnt + 3'd1;
            // Later states branch on the fields seen at DECODE so the
            // sequence is immune to IR changes mid-instruction.
            if (state == S_DECODE) begin
                opc_q <= opcode;
                op_q  <= op;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RST:      state_nx = S_FETCH;
            S_FETCH:    if (mem_last) state_nx = S_LOADIR;
            S_LOADIR:   state_nx = S_DECODE;
            S_DECODE: begin
                casez ({opcode, op})
                    5'b110_10: state_nx = S_WR_IMM;
                    5'b110_00: state_nx = S_GET_B;
                    5'b101_??: state_nx = S_GET_A;
                    5'b011_00: state_nx = S_GET_A;
                    5'b100_00: state_nx = S_GET_A;
                    default:   state_nx = S_HALT;
                endcase
            end
            S_WR_IMM:   state_nx = AFTER_DONE;
            S_GET_A: begin
                if (opc_q == 3'b101)      state_nx = S_GET_B;
                else if (opc_q == 3'b011) state_nx = S_ADDR;
                else                      state_nx = S_GET_B_RD;
            end
            S_GET_B:    state_nx = (opc_q == 3'b110) ? S_SHIFT : S_EXEC;
            S_SHIFT:    state_nx = S_WR_C;
            S_EXEC:     state_nx = (op_q == 2'b01) ? AFTER_DONE : S_WR_C;
            S_WR_C:     state_nx = AFTER_DONE;
            S_GET_B_RD: state_nx = S_ADDR;
            S_ADDR:     state_nx = (opc_q == 3'b011) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_last) state_nx = S_WR_MEM;
            S_WR_MEM:   state_nx = AFTER_DONE;
            S_MEM_WR:   if (mem_last) state_nx = AFTER_DONE;
`ifdef SEQ_STEP_EN
            S_STEP_WAIT: if (step) state_nx = S_FETCH;
`endif
            S_HALT:     state_nx = S_HALT;
            default:    state_nx = S_RST;
        endcase
    end

    always_comb begin
        pc_reset   = 1'b0;
        loadpc     = 1'b0;
        msel       = 1'b0;
        mwrite     = 1'b0;
        loadir     = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        nsel       = 2'b00;
        vsel       = 2'b00;
        write      = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (state)
            S_RST:      pc_reset = 1'b1;
            S_LOADIR: begin
                loadir = 1'b1;
                loadpc = 1'b1;
            end
            S_WR_IMM: begin
                nsel       = 2'b00;
                vsel       = 2'b10;
                write      = 1'b1;
                instr_done = 1'b1;
            end
            S_GET_A: begin
                nsel  = 2'b00;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = 2'b10;
                loadb = 1'b1;
            end
            S_SHIFT: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_EXEC: begin
                // CMP only updates status and finishes here.
                if (op_q == 2'b01) begin
                    loads      = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WR_C: begin
                nsel       = 2'b01;
                vsel       = 2'b00;
                write      = 1'b1;
                instr_done = 1'b1;
            end
            S_GET_B_RD: begin
                nsel  = 2'b01;
                loadb = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_RD:   msel = 1'b1;
            S_WR_MEM: begin
                nsel       = 2'b01;
                vsel       = 2'b11;
                write      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                msel       = 1'b1;
                mwrite     = 1'b1;
                instr_done = mem_last;
            end
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
    end

endmodule
